// File: rtl/cache_seq_pkg.sv
// Shared constants for the cache refill sequencer: FSM state codes and
// block-geometry widths derived from the number of words per block.
package cache_seq_pkg;

  localparam int ADDR_SIZE_DEF   = 32;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int BLOCK_WORDS_DEF = 8;

  // Word-counter width and byte-offset width for the default block size.
  localparam int CNT_W    = $clog2(BLOCK_WORDS_DEF);
  localparam int OFFSET_W = CNT_W + 2;

  // FSM state encoding (IDLE must stay all-zero so the reset debug view is 0).
  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOOKUP      = 3'd1;
  localparam logic [2:0] S_WRITE_MEM   = 3'd2;
  localparam logic [2:0] S_REFILL_REQ  = 3'd3;
  localparam logic [2:0] S_REFILL_DATA = 3'd4;

  // Counter width for an arbitrary block size (BLOCK_WORDS is a power of two >= 2).
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cache_refill_sequencer_block_fill_counter.sv
// Word counter used while refilling a cache block: clear, increment with
// wrap, last-word flag and the fill address inside the current block.
module block_fill_counter
  import cache_seq_pkg::*;
#(
  parameter int ADDR_SIZE   = ADDR_SIZE_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         clr_i,
  input  logic                                         inc_i,
  input  logic [ADDR_SIZE-cnt_width(BLOCK_WORDS)-3:0]  block_i,
  output logic [cnt_width(BLOCK_WORDS)-1:0]            cnt_o,
  output logic                                         last_o,
  output logic [ADDR_SIZE-1:0]                         fill_addr_o
);

  localparam int CW = cnt_width(BLOCK_WORDS);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment; the last word wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(BLOCK_WORDS - 1));
  // Concatenation keeps the word index inside the block: no carry into the tag.
  assign fill_addr_o = {block_i, cnt_q, 2'b00};

endmodule

// File: rtl/cache_refill_sequencer.sv
// Front-end controller for the data cache: one load/store at a time, lookup,
// whole-block refill on read miss followed by a replayed lookup, and
// write-through / no-write-allocate stores.
// Handshakes: a request transfers on a cycle where valid and ready are both
// high at the rising edge; valid holds its payload stable until that cycle.
module cache_refill_sequencer
  import cache_seq_pkg::*;
#(
  parameter int ADDR_SIZE   = ADDR_SIZE_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_SIZE-1:0]  cpu_addr,
  input  logic                  cpu_write,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_SIZE-1:0]  cache_addr,
  output logic                  cache_write_enable,
  output logic [DATA_WIDTH-1:0] cache_write_data,
  output logic                  cache_fill,
  output logic                  cache_fill_last,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_write,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [2:0]            dbg_state_o
);

  localparam int CW    = cnt_width(BLOCK_WORDS);
  localparam int OFF_W = CW + 2;

  logic [2:0]            state_q, state_d;
  logic [ADDR_SIZE-1:0]  req_addr_q, req_addr_d;
  logic                  req_write_q, req_write_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;

  logic                  cnt_clr, cnt_inc, cnt_last;
  logic [CW-1:0]         word_cnt;
  logic [ADDR_SIZE-1:0]  fill_addr;

  block_fill_counter #(
    .ADDR_SIZE   (ADDR_SIZE),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (cnt_clr),
    .inc_i       (cnt_inc),
    .block_i     (req_addr_q[ADDR_SIZE-1:OFF_W]),
    .cnt_o       (word_cnt),
    .last_o      (cnt_last),
    .fill_addr_o (fill_addr)
  );

  // Next-state logic, request latching and counter control.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_write_d = req_write_q;
    req_wdata_d = req_wdata_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          req_addr_d  = cpu_addr;
          req_write_d = cpu_write;
          req_wdata_d = cpu_wdata;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (req_write_q) begin
          state_d = S_WRITE_MEM;
        end else if (cache_hit) begin
          state_d = S_IDLE;
        end else begin
          cnt_clr = 1'b1;
          state_d = S_REFILL_REQ;
        end
      end
      S_WRITE_MEM: begin
        if (mem_req_ready) state_d = S_IDLE;
      end
      S_REFILL_REQ: begin
        if (mem_req_ready) state_d = S_REFILL_DATA;
      end
      S_REFILL_DATA: begin
        if (mem_rvalid) begin
          cnt_inc = 1'b1;
          state_d = cnt_last ? S_LOOKUP : S_REFILL_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state and latched request; idle buses are zero.
  always_comb begin
    cpu_req_ready      = 1'b0;
    cpu_resp_valid     = 1'b0;
    cpu_rdata          = '0;
    cache_addr         = '0;
    cache_write_enable = 1'b0;
    cache_write_data   = '0;
    cache_fill         = 1'b0;
    cache_fill_last    = 1'b0;
    mem_req_valid      = 1'b0;
    mem_write          = 1'b0;
    mem_addr           = '0;
    mem_wdata          = '0;
    case (state_q)
      S_IDLE: cpu_req_ready = 1'b1;
      S_LOOKUP: begin
        cache_addr = req_addr_q;
        if (cache_hit && !req_write_q) begin
          cpu_resp_valid = 1'b1;
          cpu_rdata      = cache_read_data;
        end
        if (cache_hit && req_write_q) begin
          cache_write_enable = 1'b1;
          cache_write_data   = req_wdata_q;
        end
      end
      S_WRITE_MEM: begin
        mem_req_valid  = 1'b1;
        mem_write      = 1'b1;
        mem_addr       = req_addr_q;
        mem_wdata      = req_wdata_q;
        cpu_resp_valid = mem_req_ready;
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = fill_addr;
      end
      S_REFILL_DATA: begin
        cache_addr = fill_addr;
        if (mem_rvalid) begin
          cache_write_enable = 1'b1;
          cache_fill         = 1'b1;
          cache_write_data   = mem_rdata;
          cache_fill_last    = cnt_last;
        end
      end
      default: ;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_write_q <= req_write_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cache_refill_sequencer.sv
// Directed bench for cache_refill_sequencer with a behavioural cache and a
// zero-wait (or stalled) memory that returns addr ^ 0xA5A5A5A5.
module tb_cache_refill_sequencer;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_RDATA  = 3'd4;

  logic        clk, rst;
  logic        cpu_req_valid, cpu_req_ready, cpu_write, cpu_resp_valid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [31:0] cache_addr, cache_write_data;
  logic        cache_write_enable, cache_fill, cache_fill_last;
  logic [31:0] cache_read_data = '0;
  logic        cache_hit = 1'b0;
  logic        mem_req_valid, mem_req_ready, mem_write, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  cache_refill_sequencer dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
    .cache_addr(cache_addr), .cache_write_enable(cache_write_enable),
    .cache_write_data(cache_write_data), .cache_fill(cache_fill),
    .cache_fill_last(cache_fill_last), .cache_read_data(cache_read_data),
    .cache_hit(cache_hit), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data returns one cycle after acceptance; reset drops it.
  logic        mem_ready_en = 1'b1;
  logic        stray_rvalid = 1'b0;
  logic        pend_v = 1'b0;
  logic [31:0] pend_d = '0;
  always @(posedge clk) begin
    if (rst) pend_v <= 1'b0;
    else begin
      pend_v <= mem_req_valid && mem_req_ready && !mem_write;
      pend_d <= mem_addr ^ 32'hA5A5A5A5;
    end
  end
  assign mem_req_ready = mem_ready_en;
  assign mem_rvalid    = pend_v | stray_rvalid;
  assign mem_rdata     = pend_d;

  // Cache model: words by address, blocks valid after the last fill word.
  logic [31:0] cmem [logic [31:0]];
  bit          cvalid [logic [31:0]];
  int          cache_upd = 0;
  always @(posedge clk) begin : cache_wr
    logic [31:0] wa, ba;
    if (cache_write_enable) begin
      wa = {cache_addr[31:2], 2'b00};
      ba = cache_addr & ~32'h1F;
      if (cache_fill) begin
        cmem[wa] = cache_write_data;
        if (cache_fill_last) cvalid[ba] = 1'b1;
      end else if (cvalid.exists(ba)) begin
        cmem[wa] = cache_write_data;
      end
      cache_upd <= cache_upd + 1;
    end
  end
  always @(cache_addr or cache_upd) begin : cache_rd
    logic [31:0] wa, ba;
    wa = {cache_addr[31:2], 2'b00};
    ba = cache_addr & ~32'h1F;
    cache_hit       = cvalid.exists(ba);
    cache_read_data = cmem.exists(wa) ? cmem[wa] : 32'h0;
  end

  // Monitor, sampled 2 time units after the falling edge.
  int acc_cnt = 0, resp_cnt = 0, mw_cnt = 0, nf_cw_cnt = 0, fill_cnt = 0;
  int last_cnt = 0, last_fill_idx = 0, replay_miss = 0, resp_cyc = -1;
  logic [31:0] resp_data = '0, mw_addr = '0, mw_data = '0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  bit after_last = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (cpu_req_valid && cpu_req_ready) acc_cnt++;
    if (cpu_resp_valid) begin
      resp_cnt++; resp_cyc = cyc; resp_data = cpu_rdata;
    end
    if (mem_req_valid && mem_req_ready) begin
      if (mem_write) begin
        mw_cnt++; mw_addr = mem_addr; mw_data = mem_wdata;
      end else got_q.push_back(mem_addr);
    end
    if (after_last) begin
      if (dbg_state == ST_LOOKUP && !cache_hit) replay_miss++;
      after_last = 1'b0;
    end
    if (cache_write_enable) begin
      if (cache_fill) fill_cnt++;
      else nf_cw_cnt++;
      if (cache_fill_last) begin
        last_cnt++; last_fill_idx = fill_cnt; after_last = 1'b1;
      end
    end
  end

  // Scoreboard counters
  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input bit hold, output int t);
    t = -1;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_addr = a; cpu_write = w; cpu_wdata = d;
    for (int i = 0; i < 64; i++) begin
      if (cpu_req_ready) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    check("accept_seen", (t >= 0) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    if (!hold) cpu_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int t0, input int n0, input int max, output int lat);
    lat = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #3;
      if (resp_cnt > n0) begin
        lat = resp_cyc - t0;
        break;
      end
    end
  endtask

  task automatic check_reads(input string tag, input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(base + 32'(4 * i));
    check({tag, "_nreads"}, 32'(got_q.size()), 32'd8);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_raddr"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
  endtask

  int t, lat, n0, a0, f0, l0, mw0, nf0;

  initial begin
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_addr = '0; cpu_write = 1'b0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_ready", {31'd0, cpu_req_ready}, 32'd1);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_cache_addr", cache_addr, 32'd0);
    check("rst_resp", {31'd0, cpu_resp_valid}, 32'd0);
    check("rst_cwe", {31'd0, cache_write_enable}, 32'd0);
    rst = 1'b0;
    got_q.delete();

    // Cold read miss: 8-word refill, replay hits, response 18 cycles after accept.
    n0 = resp_cnt; l0 = last_cnt; f0 = fill_cnt; mw0 = mw_cnt;
    issue(32'h100, 1'b0, 32'h0, 1'b0, t);
    wait_resp(t, n0, 60, lat);
    check("miss_lat", 32'(lat), 32'd18);
    check("miss_data", resp_data, 32'hA5A5A4A5);
    check("miss_nlast", 32'(last_cnt - l0), 32'd1);
    check("miss_last_on_8th", 32'(last_fill_idx - f0), 32'd8);
    check("miss_nfill", 32'(fill_cnt - f0), 32'd8);
    check("miss_no_mw", 32'(mw_cnt - mw0), 32'd0);
    check_reads("miss", 32'h100);

    // Read hit in the same block: one cycle, no memory traffic.
    n0 = resp_cnt;
    issue(32'h104, 1'b0, 32'h0, 1'b0, t);
    wait_resp(t, n0, 10, lat);
    check("hit_lat", 32'(lat), 32'd1);
    check("hit_data", resp_data, 32'hA5A5A4A1);
    check("hit_no_mreq", 32'(got_q.size()), 32'd0);

    // Store hit with memory ready held low for 3 WRITE_MEM cycles.
    n0 = resp_cnt; mw0 = mw_cnt; nf0 = nf_cw_cnt;
    mem_ready_en = 1'b0;
    issue(32'h104, 1'b1, 32'hDEADBEEF, 1'b0, t);
    while (cyc < t + 5) @(negedge clk);
    mem_ready_en = 1'b1;
    wait_resp(t, n0, 20, lat);
    check("st_lat", 32'(lat), 32'd5);
    check("st_cache_wr", 32'(nf_cw_cnt - nf0), 32'd1);
    check("st_nmw", 32'(mw_cnt - mw0), 32'd1);
    check("st_mw_addr", mw_addr, 32'h104);
    check("st_mw_data", mw_data, 32'hDEADBEEF);
    n0 = resp_cnt;
    issue(32'h104, 1'b0, 32'h0, 1'b0, t);
    wait_resp(t, n0, 10, lat);
    check("st_readback", resp_data, 32'hDEADBEEF);
    check("st_readback_lat", 32'(lat), 32'd1);

    // Store miss: memory write only, no cache write, no refill.
    n0 = resp_cnt; mw0 = mw_cnt; nf0 = nf_cw_cnt; f0 = fill_cnt;
    issue(32'h2000, 1'b1, 32'h12345678, 1'b0, t);
    wait_resp(t, n0, 20, lat);
    check("stm_lat", 32'(lat), 32'd2);
    check("stm_no_cache_wr", 32'(nf_cw_cnt - nf0 + fill_cnt - f0), 32'd0);
    check("stm_nmw", 32'(mw_cnt - mw0), 32'd1);
    check("stm_mw_addr", mw_addr, 32'h2000);
    check("stm_no_refill", 32'(got_q.size()), 32'd0);

    // Stray mem_rvalid and mem_req_ready while idle are ignored.
    nf0 = nf_cw_cnt; f0 = fill_cnt;
    @(negedge clk); stray_rvalid = 1'b1;
    @(negedge clk); stray_rvalid = 1'b0;
    #3;
    check("stray_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("stray_no_cwe", 32'(nf_cw_cnt - nf0 + fill_cnt - f0), 32'd0);

    // Reset in the middle of a refill, then a full refill of the same block.
    f0 = fill_cnt;
    issue(32'h300, 1'b0, 32'h0, 1'b0, t);
    for (int i = 0; i < 40 && (fill_cnt - f0) < 3; i++) begin
      @(negedge clk); #3;
    end
    for (int i = 0; i < 10 && dbg_state != ST_RDATA; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #3;
    check("mid_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("mid_rst_ready", {31'd0, cpu_req_ready}, 32'd1);
    check("mid_rst_mvalid", {31'd0, mem_req_valid}, 32'd0);
    check("mid_rst_cwe", {31'd0, cache_write_enable}, 32'd0);
    rst = 1'b0;
    got_q.delete();
    n0 = resp_cnt; l0 = last_cnt;
    issue(32'h300, 1'b0, 32'h0, 1'b0, t);
    wait_resp(t, n0, 60, lat);
    check("rerefill_lat", 32'(lat), 32'd18);
    check("rerefill_data", resp_data, 32'hA5A5A6A5);
    check("rerefill_nlast", 32'(last_cnt - l0), 32'd1);
    check_reads("rerefill", 32'h300);

    // Valid held high across a miss: one acceptance per response, back-to-back.
    n0 = resp_cnt; a0 = acc_cnt;
    issue(32'h400, 1'b0, 32'h0, 1'b1, t);
    while (cyc < t + 20) @(negedge clk);
    cpu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("hold_nacc", 32'(acc_cnt - a0), 32'd2);
    check("hold_nresp", 32'(resp_cnt - n0), 32'd2);
    check("hold_b2b_cyc", 32'(resp_cyc - t), 32'd20);
    check("hold_data", resp_data, 32'hA5A5A1A5);
    check_reads("hold", 32'h400);

    // Top of the address space: fill addresses stay inside the block.
    n0 = resp_cnt;
    issue(32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, t);
    wait_resp(t, n0, 60, lat);
    check("top_lat", 32'(lat), 32'd18);
    check("top_data", resp_data, 32'h5A5A5A59);
    check_reads("top", 32'hFFFFFFE0);

    check("replay_misses", 32'(replay_miss), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
